mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4-to-1 multiplexer between four requesters. It produces registered select lines s1/s0 for the mux, plus a one-hot grant back to the requesters. An owner keeps the grant while its request stays high, for at most MAX_HOLD cycles when other requesters are waiting. It sits directly in front of the mux select inputs in the datapath.

---
 rtl/mux4_rr_arbiter_if.sv | 47 ++++
 rtl/mux4_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter_if
//
// Bundles the request/grant handshake and the mux select outputs of the
// four-way round-robin arbiter into a single interface.
//
// Signals:
//   req       [3:0]  request vector, bit i = requester i wants the shared mux
//   gnt       [3:0]  registered one-hot grant (all-zero when nobody owns the mux)
//   s1, s0           registered mux select, {s1,s0} = owner index
//   busy             registered, high while gnt is non-zero
//   switch_p         registered one-cycle pulse when a new owner takes the mux
//
// Modports:
//   slave   - the arbiter side (consumes req, produces grant/select)
//   master  - the requester / datapath side (produces req, consumes grant)
// -----------------------------------------------------------------------------
interface mux4_rr_arbiter_if;

   logic [3:0] req;
   logic [3:0] gnt;
   logic       s1;
   logic       s0;
   logic       busy;
   logic       switch_p;

   // The arbiter reads requests and drives every registered output.
   modport slave (
      input  req,
      output gnt,
      output s1,
      output s0,
      output busy,
      output switch_p
   );

   // The requester side drives requests and watches the grant and select.
   modport master (
      output req,
      input  gnt,
      input  s1,
      input  s0,
      input  busy,
      input  switch_p
   );

endinterface

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter sharing one 4-to-1 multiplexer between four requesters.
// The owner keeps the mux while its request stays high, but is forced to hand
// over after MAX_HOLD consecutive cycles whenever somebody else is waiting.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles while others wait (1..255)
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous active-high reset
//   bus    mux4_rr_arbiter_if.slave: req in; gnt, s1, s0, busy, switch_p out
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input logic              clk,
   input logic              reset,
   mux4_rr_arbiter_if.slave bus
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   // The hold counter only ever counts up to this value before wrapping or rotating.
   localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

   state_t     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] sel_q, sel_d;
   logic       busy_q, busy_d;
   logic       switch_q, switch_d;
   logic [7:0] holdCnt_q, holdCnt_d;
   logic [1:0] last_q, last_d;

   logic [3:0] ownerMask;
   logic [3:0] otherReq;
   logic       doGrant;
   logic       goIdle;
   logic [1:0] grantIdx;

   // Round-robin search starting just after lastIdx and wrapping back to lastIdx
   // itself. The loop runs from the farthest candidate to the nearest so that
   // the nearest requester set in candidates overwrites the result last.
   function automatic logic [1:0] rrPick(input logic [3:0] candidates,
                                         input logic [1:0] lastIdx);
      logic [1:0] idx;
      rrPick = lastIdx;
      for (int k = 4; k >= 1; k--) begin
         idx = lastIdx + 2'(k);
         if (candidates[idx]) begin
            rrPick = idx;
         end
      end
   endfunction

   // While granted, last_q is the current owner. Removing the owner from the
   // request vector lets a hand-off skip the owner and land on the next
   // waiting requester in round-robin order.
   always_comb begin
      ownerMask = 4'b0001 << last_q;
      otherReq  = bus.req & ~ownerMask;
   end

   // Next-state decision. IDLE grants to whoever wins the round-robin search.
   // GRANT handles release, the hold limit, and normal holding. Release is
   // checked first, so a release on the same edge as the hold limit counts as
   // a release. Both paths end in doGrant (new owner) or goIdle (drop the grant).
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      sel_d     = sel_q;
      busy_d    = busy_q;
      switch_d  = 1'b0;
      holdCnt_d = holdCnt_q;
      last_d    = last_q;
      doGrant   = 1'b0;
      goIdle    = 1'b0;
      grantIdx  = last_q;

      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               doGrant  = 1'b1;
               grantIdx = rrPick(bus.req, last_q);
            end
         end

         GRANT: begin
            if (!bus.req[last_q]) begin
               if (|otherReq) begin
                  doGrant  = 1'b1;
                  grantIdx = rrPick(otherReq, last_q);
               end else begin
                  goIdle = 1'b1;
               end
            end else if (holdCnt_q == HOLD_LIMIT) begin
               if (|otherReq) begin
                  doGrant  = 1'b1;
                  grantIdx = rrPick(otherReq, last_q);
               end else begin
                  holdCnt_d = 8'd0;
               end
            end else begin
               holdCnt_d = holdCnt_q + 8'd1;
            end
         end

         default: begin
            goIdle = 1'b1;
         end
      endcase

      if (doGrant) begin
         state_d   = GRANT;
         gnt_d     = 4'b0001 << grantIdx;
         sel_d     = grantIdx;
         busy_d    = 1'b1;
         switch_d  = 1'b1;
         holdCnt_d = 8'd0;
         last_d    = grantIdx;
      end else if (goIdle) begin
         state_d   = IDLE;
         gnt_d     = 4'b0000;
         busy_d    = 1'b0;
         holdCnt_d = 8'd0;
      end
   end

   // State and output registers. After reset last_q is 3, so the first
   // round-robin search starts at requester 0. The select register is not
   // changed when the arbiter goes idle, so it keeps the last owner's index.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         gnt_q     <= 4'b0000;
         sel_q     <= 2'd0;
         busy_q    <= 1'b0;
         switch_q  <= 1'b0;
         holdCnt_q <= 8'd0;
         last_q    <= 2'd3;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         sel_q     <= sel_d;
         busy_q    <= busy_d;
         switch_q  <= switch_d;
         holdCnt_q <= holdCnt_d;
         last_q    <= last_d;
      end
   end

   // Every output comes straight from a register, so the mux select lines
   // have no combinational path from req.
   always_comb begin
      bus.gnt      = gnt_q;
      bus.s1       = sel_q[1];
      bus.s0       = sel_q[0];
      bus.busy     = busy_q;
      bus.switch_p = switch_q;
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//
// Drives two arbiter instances from the same request and reset stimulus:
// instance A uses MAX_HOLD=2 and instance B uses MAX_HOLD=8. A behavioural
// model predicts the outputs of each instance and queues them. A negedge
// process pops and compares them. The scenario tasks also compare
// hand-derived constants at the key cycles.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
      logic       sw;
   } exp_t;

   logic clk;
   logic reset;

   int passCount  = 0;
   int checkCount = 0;

   exp_t qA[$];
   exp_t qB[$];

   // Model state per instance (0 = A, 1 = B); owner -1 means no owner.
   int         mOwner[2];
   int         mHold[2];
   logic [1:0] mLast[2];
   logic [1:0] mSel[2];
   int         mMax[2];

   mux4_rr_arbiter_if ifA ();
   mux4_rr_arbiter_if ifB ();

   mux4_rr_arbiter #(.MAX_HOLD(2)) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (ifA)
   );

   mux4_rr_arbiter #(.MAX_HOLD(8)) dutB (
      .clk   (clk),
      .reset (reset),
      .bus   (ifB)
   );

   // Free-running clock with a period of 10 time units.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Round-robin search that returns the first set index after last, or -1 if none is set.
   function automatic int pickRr(input logic [3:0] r, input logic [1:0] last);
      int i;
      for (int k = 1; k <= 4; k++) begin
         i = (int'(last) + k) % 4;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   // Advances the model of instance u by one clock edge and returns the registered outputs after that edge.
   task automatic modelStep(input int u, input logic [3:0] r, input logic rst, output exp_t e);
      int         next;
      logic       sw;
      logic [3:0] others;
      if (rst) begin
         mOwner[u] = -1;
         mHold[u]  = 0;
         mLast[u]  = 2'd3;
         mSel[u]   = 2'd0;
         e         = '0;
      end else begin
         next = mOwner[u];
         sw   = 1'b0;
         if (mOwner[u] < 0) begin
            if (r != 4'b0000) begin
               next = pickRr(r, mLast[u]);
               sw   = 1'b1;
            end
         end else begin
            others = r;
            others[mOwner[u]] = 1'b0;
            if (!r[mOwner[u]] || (mHold[u] == mMax[u] - 1 && others != 4'b0000)) begin
               next = (others != 4'b0000) ? pickRr(others, mLast[u]) : -1;
               sw   = (next >= 0);
            end
         end
         if (sw || next < 0 || mHold[u] == mMax[u] - 1) mHold[u] = 0;
         else mHold[u] = mHold[u] + 1;
         mOwner[u] = next;
         if (next >= 0) begin
            mLast[u] = 2'(next);
            mSel[u]  = 2'(next);
         end
         e.gnt  = (next >= 0) ? (4'b0001 << next) : 4'b0000;
         e.sel  = mSel[u];
         e.busy = (next >= 0);
         e.sw   = sw;
      end
   endtask

   // Applies one cycle of stimulus to both instances and queues each model's prediction for the next edge.
   task automatic applyStimulus(input logic [3:0] r, input logic rst);
      exp_t eA, eB;
      ifA.req = r;
      ifB.req = r;
      reset   = rst;
      modelStep(0, r, rst, eA);
      modelStep(1, r, rst, eB);
      qA.push_back(eA);
      qB.push_back(eB);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: on each falling edge, pops one prediction per instance and compares it with the DUT outputs.
   always @(negedge clk) begin
      exp_t e;
      if (qA.size() > 0) begin
         e = qA.pop_front();
         checkCount++;
         if ({ifA.gnt, ifA.s1, ifA.s0, ifA.busy, ifA.switch_p} !== e)
            $display("[TB] FAIL sbA t=%0t: gnt/sel/busy/sw got %b %b%b %b %b required %b %b %b %b",
                     $time, ifA.gnt, ifA.s1, ifA.s0, ifA.busy, ifA.switch_p, e.gnt, e.sel, e.busy, e.sw);
         else passCount++;
      end
      if (qB.size() > 0) begin
         e = qB.pop_front();
         checkCount++;
         if ({ifB.gnt, ifB.s1, ifB.s0, ifB.busy, ifB.switch_p} !== e)
            $display("[TB] FAIL sbB t=%0t: gnt/sel/busy/sw got %b %b%b %b %b required %b %b %b %b",
                     $time, ifB.gnt, ifB.s1, ifB.s0, ifB.busy, ifB.switch_p, e.gnt, e.sel, e.busy, e.sw);
         else passCount++;
      end
   end

   // Reset is held with every request high; both instances stay cleared, and the first free edge grants requester 0.
   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         applyStimulus(4'b1111, 1'b1);
         checkCount++;
         if ({ifA.gnt, ifA.s1, ifA.s0, ifA.busy, ifB.gnt, ifB.s1, ifB.s0, ifB.busy} !== 14'b0)
            $display("[TB] FAIL reset_hold: got A=%b%b%b%b B=%b%b%b%b required all zero",
                     ifA.gnt, ifA.s1, ifA.s0, ifA.busy, ifB.gnt, ifB.s1, ifB.s0, ifB.busy);
         else passCount++;
      end
      applyStimulus(4'b1111, 1'b0);
      checkCount++;
      if (ifA.gnt !== 4'b0001 || {ifA.s1, ifA.s0} !== 2'b00 || ifA.switch_p !== 1'b1 || ifB.gnt !== 4'b0001)
         $display("[TB] FAIL reset_first_grant: got gntA=%b sel=%b%b sw=%b gntB=%b required 0001 00 1 0001",
                  ifA.gnt, ifA.s1, ifA.s0, ifA.switch_p, ifB.gnt);
      else passCount++;
   endtask

   // A single requester keeps the grant beyond MAX_HOLD on instance B, with switch_p pulsing only once.
   task automatic test_single();
      int swCount;
      swCount = 0;
      applyStimulus(4'b0000, 1'b1);
      for (int c = 0; c < 10; c++) begin
         applyStimulus(4'b0100, 1'b0);
         if (ifB.switch_p === 1'b1) swCount++;
         checkCount++;
         if (ifB.gnt !== 4'b0100 || {ifB.s1, ifB.s0} !== 2'b10 || ifB.busy !== 1'b1)
            $display("[TB] FAIL single_hold c=%0d: got gnt=%b sel=%b%b busy=%b required 0100 10 1",
                     c, ifB.gnt, ifB.s1, ifB.s0, ifB.busy);
         else passCount++;
      end
      checkCount++;
      if (swCount !== 1) $display("[TB] FAIL single_switch_count: got %0d required 1", swCount);
      else passCount++;
      applyStimulus(4'b0000, 1'b0);
      checkCount++;
      if (ifB.gnt !== 4'b0000 || ifB.busy !== 1'b0 || {ifB.s1, ifB.s0} !== 2'b10)
         $display("[TB] FAIL single_release: got gnt=%b busy=%b sel=%b%b required 0000 0 10",
                  ifB.gnt, ifB.busy, ifB.s1, ifB.s0);
      else passCount++;
   endtask

   // With every request held high on instance A (MAX_HOLD=2), owners rotate 0,1,2,3 and each keeps the grant for two cycles.
   task automatic test_fairness();
      int expOwner[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      logic [3:0] expGnt;
      logic       expSw;
      applyStimulus(4'b0000, 1'b1);
      for (int c = 0; c < 9; c++) begin
         applyStimulus(4'b1111, 1'b0);
         expGnt = 4'b0001 << expOwner[c];
         expSw  = (c % 2 == 0);
         checkCount++;
         if (ifA.gnt !== expGnt || {ifA.s1, ifA.s0} !== 2'(expOwner[c]) || ifA.switch_p !== expSw)
            $display("[TB] FAIL fairness c=%0d: got gnt=%b sel=%b%b sw=%b required %b %0d %b",
                     c, ifA.gnt, ifA.s1, ifA.s0, ifA.switch_p, expGnt, expOwner[c], expSw);
         else passCount++;
      end
   endtask

   // Owner 1 releases while requesters 0 and 3 wait: the grant goes to 3 with no idle cycle, then from 3 to 0.
   task automatic test_release_handoff();
      applyStimulus(4'b0000, 1'b1);
      applyStimulus(4'b0010, 1'b0);
      checkCount++;
      if (ifA.gnt !== 4'b0010) $display("[TB] FAIL handoff_owner1: got %b required 0010", ifA.gnt);
      else passCount++;
      applyStimulus(4'b1001, 1'b0);
      checkCount++;
      if (ifA.gnt !== 4'b1000 || {ifA.s1, ifA.s0} !== 2'b11 || ifA.switch_p !== 1'b1 || ifA.busy !== 1'b1)
         $display("[TB] FAIL handoff_to3: got gnt=%b sel=%b%b sw=%b busy=%b required 1000 11 1 1",
                  ifA.gnt, ifA.s1, ifA.s0, ifA.switch_p, ifA.busy);
      else passCount++;
      applyStimulus(4'b0001, 1'b0);
      checkCount++;
      if (ifA.gnt !== 4'b0001 || {ifA.s1, ifA.s0} !== 2'b00 || ifA.switch_p !== 1'b1)
         $display("[TB] FAIL handoff_to0: got gnt=%b sel=%b%b sw=%b required 0001 00 1",
                  ifA.gnt, ifA.s1, ifA.s0, ifA.switch_p);
      else passCount++;
   endtask

   // Owner 2 reaches the hold limit on A and releases on the same edge that req[0] rises: the grant moves straight to 0.
   task automatic test_collision();
      applyStimulus(4'b0000, 1'b1);
      applyStimulus(4'b0100, 1'b0);
      applyStimulus(4'b0100, 1'b0);
      checkCount++;
      if (ifA.gnt !== 4'b0100 || ifA.switch_p !== 1'b0)
         $display("[TB] FAIL collision_hold: got gnt=%b sw=%b required 0100 0", ifA.gnt, ifA.switch_p);
      else passCount++;
      applyStimulus(4'b0001, 1'b0);
      checkCount++;
      if (ifA.gnt !== 4'b0001 || ifA.switch_p !== 1'b1 || ifA.busy !== 1'b1 || ifB.gnt !== 4'b0001)
         $display("[TB] FAIL collision_move: got gntA=%b sw=%b busy=%b gntB=%b required 0001 1 1 0001",
                  ifA.gnt, ifA.switch_p, ifA.busy, ifB.gnt);
      else passCount++;
   endtask

   // Reset mid-grant on B (owner 3, hold_cnt=4) drops the grant; afterwards requester 3 alone wins again.
   task automatic test_mid_reset();
      applyStimulus(4'b0000, 1'b1);
      for (int c = 0; c < 5; c++) applyStimulus(4'b1000, 1'b0);
      applyStimulus(4'b1000, 1'b1);
      checkCount++;
      if (ifB.gnt !== 4'b0000 || {ifB.s1, ifB.s0} !== 2'b00 || ifB.busy !== 1'b0)
         $display("[TB] FAIL midreset_drop: got gnt=%b sel=%b%b busy=%b required 0000 00 0",
                  ifB.gnt, ifB.s1, ifB.s0, ifB.busy);
      else passCount++;
      applyStimulus(4'b1000, 1'b0);
      checkCount++;
      if (ifB.gnt !== 4'b1000 || {ifB.s1, ifB.s0} !== 2'b11 || ifB.switch_p !== 1'b1)
         $display("[TB] FAIL midreset_regrant: got gnt=%b sel=%b%b sw=%b required 1000 11 1",
                  ifB.gnt, ifB.s1, ifB.s0, ifB.switch_p);
      else passCount++;
   endtask

   // Runs the scenarios in sequence, lets the scoreboard drain, then prints the summary line.
   initial begin
      mMax[0] = 2;
      mMax[1] = 8;
      mOwner  = '{-1, -1};
      mHold   = '{0, 0};
      mLast   = '{2'd3, 2'd3};
      mSel    = '{2'd0, 2'd0};
      reset   = 1'b1;
      ifA.req = 4'b0000;
      ifB.req = 4'b0000;

      test_reset();
      test_single();
      test_fairness();
      test_release_handoff();
      test_collision();
      test_mid_reset();
      applyStimulus(4'b0000, 1'b0);

      @(negedge clk);
      #1;
      checkCount++;
      if (qA.size() != 0 || qB.size() != 0)
         $display("[TB] FAIL scoreboard_drain: got %0d/%0d left required 0/0", qA.size(), qB.size());
      else passCount++;

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
